// File: rtl/cobalt_pkg.sv
// cobalt_pkg: shared tag/data widths and issue-queue entry layout for all issue queues
package cobalt_pkg;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic valid;
    logic rsready;
    logic [DATA_W-1:0] rsdata;
    logic [TAG_W-1:0] rstag;
    logic rtready;
    logic [DATA_W-1:0] rtdata;
    logic [TAG_W-1:0] rttag;
    logic [TAG_W-1:0] rdtag;
  } iq_entry_t;
endpackage

// File: rtl/issueque_entry.sv
// issueque_entry: one queue slot; ports: clk, reset, flush, ld_disp/disp (write from dispatch), ld_up/up (shift from upper neighbour), cdb_* (wakeup), q (stored entry)
module issueque_entry import cobalt_pkg::*; (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic ld_disp,
  input logic ld_up,
  input iq_entry_t disp,
  input iq_entry_t up,
  input logic cdb_valid,
  input logic [TAG_W-1:0] cdb_tag,
  input logic [DATA_W-1:0] cdb_data,
  output iq_entry_t q
);
  iq_entry_t s;
  logic wake_rs, wake_rt;
  // wakeup acts on whichever source is being loaded, so dispatch bypass and post-collapse wakeup come for free
  always_comb begin
    s = ld_disp ? disp : ld_up ? up : q;
    wake_rs = cdb_valid && s.valid && !s.rsready && s.rstag == cdb_tag;
    wake_rt = cdb_valid && s.valid && !s.rtready && s.rttag == cdb_tag;
  end
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (flush) q.valid <= 1'b0;
    else begin
      q <= s;
      if (wake_rs) begin
        q.rsready <= 1'b1;
        q.rsdata <= cdb_data;
      end
      if (wake_rt) begin
        q.rtready <= 1'b1;
        q.rtdata <= cdb_data;
      end
    end
endmodule

// File: rtl/issueque_div.sv
// issueque_div: collapsing reservation station for the divider; ports: dispatch_* in, cdb_* snoop, issuediv_busy in, issueque_full and issuediv_* out
module issueque_div import cobalt_pkg::*; #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic dispatch_en,
  input logic [DATA_W-1:0] dispatch_rsdata,
  input logic dispatch_rsready,
  input logic [TAG_W-1:0] dispatch_rstag,
  input logic [DATA_W-1:0] dispatch_rtdata,
  input logic dispatch_rtready,
  input logic [TAG_W-1:0] dispatch_rttag,
  input logic [TAG_W-1:0] dispatch_rdtag,
  input logic cdb_valid,
  input logic [TAG_W-1:0] cdb_tag,
  input logic [DATA_W-1:0] cdb_data,
  input logic issuediv_busy,
  output logic issueque_full,
  output logic issuediv_enable,
  output logic [DATA_W-1:0] issuediv_rsdata,
  output logic [DATA_W-1:0] issuediv_rtdata,
  output logic [TAG_W-1:0] issuediv_rdtag
);
  localparam int CW = $clog2(DEPTH + 1);
  iq_entry_t e [DEPTH+1];
  iq_entry_t disp;
  logic [CW-1:0] count, wr_idx, sel;
  logic has_rdy, issue, accept;
  // slot DEPTH is a permanently empty neighbour so the top entry empties on collapse
  assign e[DEPTH] = '0;
  assign disp = '{valid: 1'b1, rsready: dispatch_rsready, rsdata: dispatch_rsdata, rstag: dispatch_rstag,
                  rtready: dispatch_rtready, rtdata: dispatch_rtdata, rttag: dispatch_rttag, rdtag: dispatch_rdtag};
  always_comb begin
    sel = '0;
    has_rdy = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (e[k].valid && e[k].rsready && e[k].rtready) begin
        sel = CW'(k);
        has_rdy = 1'b1;
      end
  end
  // the enable term gives the divider one cycle to raise busy after each issue
  assign issue = has_rdy && !issuediv_busy && !issuediv_enable;
  assign accept = dispatch_en && count != CW'(DEPTH);
  assign wr_idx = count - CW'(issue);
  assign issueque_full = count == CW'(DEPTH);
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    issueque_entry u_ent (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .ld_disp(accept && wr_idx == CW'(i)),
      .ld_up(issue && CW'(i) >= sel),
      .disp(disp),
      .up(e[i+1]),
      .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag),
      .cdb_data(cdb_data),
      .q(e[i])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      count <= '0;
      issuediv_enable <= 1'b0;
      issuediv_rsdata <= '0;
      issuediv_rtdata <= '0;
      issuediv_rdtag <= '0;
    end else if (flush) begin
      count <= '0;
      issuediv_enable <= 1'b0;
    end else begin
      count <= count + CW'(accept) - CW'(issue);
      issuediv_enable <= issue;
      if (issue) begin
        issuediv_rsdata <= e[sel].rsdata;
        issuediv_rtdata <= e[sel].rtdata;
        issuediv_rdtag <= e[sel].rdtag;
      end
    end
endmodule
